// File: rtl/multi_tone_nco.sv
// rtl/multi_tone_nco.sv - multi-tone phase-accumulator source with saturated sum and coherent retune
module multi_tone_nco #(
  parameter int NUM_TONES      = 2,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int SAMPLE_WIDTH   = 15,
  parameter int OUT_WIDTH      = 16,
  localparam int TONE_IDX_W    = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clk_enable,
  input  logic [NUM_TONES-1:0]        i_tone_en,
  input  logic                        i_cfg_we,
  input  logic [TONE_IDX_W-1:0]       i_cfg_tone,
  input  logic [PHASE_WIDTH-1:0]      i_cfg_phase_inc,
  input  logic                        i_cfg_commit,
  output logic                        o_cfg_ready,
  input  logic                        i_clear_sat,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_sat
);

  localparam int  LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam int  SUM_W     = SAMPLE_WIDTH + $clog2(NUM_TONES);
  // One guard bit above the wider of sum/output keeps the clip compare exact.
  localparam int  CMP_W     = ((SUM_W > OUT_WIDTH) ? SUM_W : OUT_WIDTH) + 1;
  localparam real PI        = 3.14159265358979323846;
  localparam real AMP       = (2.0 ** (SAMPLE_WIDTH - 1)) - 1.0;

  localparam logic signed [CMP_W-1:0] OUT_MAX =
    {{(CMP_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [CMP_W-1:0] OUT_MIN =
    {{(CMP_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t                          state_q;
  logic                            ready_q;
  logic [PHASE_WIDTH-1:0]          acc_q        [NUM_TONES];
  logic [PHASE_WIDTH-1:0]          active_inc_q [NUM_TONES];
  logic [PHASE_WIDTH-1:0]          shadow_inc_q [NUM_TONES];
  logic signed [SAMPLE_WIDTH-1:0]  sample_q     [NUM_TONES];
  logic signed [OUT_WIDTH-1:0]     data_q;
  logic signed [OUT_WIDTH-1:0]     data_d;
  logic                            stage1_full_q;
  logic                            valid_q;
  logic                            sat_q;
  logic signed [CMP_W-1:0]         sum_c;
  logic                            clip_c;
  logic signed [SAMPLE_WIDTH-1:0]  lut [LUT_DEPTH];

  // Full-cycle sine table, rounded half away from zero, built at elaboration.
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam real SCALED = AMP * $sin(2.0 * PI * k / LUT_DEPTH);
    localparam int  VAL    = (SCALED >= 0.0) ? $rtoi(SCALED + 0.5) : -$rtoi(0.5 - SCALED);
    assign lut[k] = SAMPLE_WIDTH'(VAL);
  end

  // Shadow increments load on any write strobe; unknown tone indices match nothing.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_TONES; k++) shadow_inc_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_TONES; k++) begin
        if (i_cfg_we && (i_cfg_tone == TONE_IDX_W'(k))) shadow_inc_q[k] <= i_cfg_phase_inc;
      end
    end
  end

  // Commit handshake: a request waits for the next enabled edge, then all tones retune together.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      for (int k = 0; k < NUM_TONES; k++) active_inc_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cfg_commit) begin
            state_q <= ST_PENDING;
            ready_q <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (i_clk_enable) begin
            for (int k = 0; k < NUM_TONES; k++) active_inc_q[k] <= shadow_inc_q[k];
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Phase accumulators run whether or not the tone is gated, so re-enabling stays phase-continuous.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_TONES; k++) acc_q[k] <= '0;
    end else if (i_clk_enable) begin
      for (int k = 0; k < NUM_TONES; k++) acc_q[k] <= acc_q[k] + active_inc_q[k];
    end
  end

  // Stage 1: table lookup from the accumulator's top bits, zeroed for gated tones.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_TONES; k++) sample_q[k] <= '0;
    end else if (i_clk_enable) begin
      for (int k = 0; k < NUM_TONES; k++) begin
        sample_q[k] <= i_tone_en[k] ? lut[acc_q[k][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]] : '0;
      end
    end
  end

  // Full-precision sum of the stage-1 samples and clamp into the output range.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_TONES; k++) sum_c = sum_c + CMP_W'(sample_q[k]);
    clip_c = 1'b0;
    data_d = sum_c[OUT_WIDTH-1:0];
    if (sum_c > OUT_MAX) begin
      data_d = OUT_MAX[OUT_WIDTH-1:0];
      clip_c = 1'b1;
    end else if (sum_c < OUT_MIN) begin
      data_d = OUT_MIN[OUT_WIDTH-1:0];
      clip_c = 1'b1;
    end
  end

  // Stage 2: register the saturated sum.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) data_q <= '0;
    else if (i_clk_enable) data_q <= data_d;
  end

  // Sticky clip flag; a clip on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) sat_q <= 1'b0;
    else if (i_clk_enable && clip_c) sat_q <= 1'b1;
    else if (i_clear_sat) sat_q <= 1'b0;
  end

  // Valid marks an enabled edge that loaded a sample which passed through both stages.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stage1_full_q <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= i_clk_enable && stage1_full_q;
      if (i_clk_enable) stage1_full_q <= 1'b1;
    end
  end

  assign o_cfg_ready = ready_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sat       = sat_q;

endmodule

// File: tb/tb_multi_tone_nco.sv
// tb/tb_multi_tone_nco.sv - scoreboard bench for multi_tone_nco
module tb_multi_tone_nco;

  localparam int NT = 3;

  logic              clk;
  logic              rst_n;
  logic              clken;
  logic [NT-1:0]     tone_en;
  logic              we;
  logic [1:0]        tone;
  logic [31:0]       pinc;
  logic              commit;
  logic              ready;
  logic              clear_sat;
  logic signed [15:0] data;
  logic              valid;
  logic              sat;

  multi_tone_nco #(
    .NUM_TONES(NT), .PHASE_WIDTH(32), .LUT_ADDR_WIDTH(10), .SAMPLE_WIDTH(15), .OUT_WIDTH(16)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_clk_enable(clken), .i_tone_en(tone_en),
    .i_cfg_we(we), .i_cfg_tone(tone), .i_cfg_phase_inc(pinc), .i_cfg_commit(commit),
    .o_cfg_ready(ready), .i_clear_sat(clear_sat), .o_data(data), .o_valid(valid), .o_sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          lut_ref [1024];
  logic [31:0] m_acc [NT];
  logic [31:0] m_inc [NT];
  logic [31:0] m_shadow [NT];
  bit          m_pending;
  bit          m_full;
  int          exp_q [$];
  int          obs_max;
  int          obs_min;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    obs_max = -100000;
    obs_min = 100000;
  endtask

  // Drive one clock with the currently set inputs; model advances, DUT is compared after the edge.
  task automatic cycle();
    int s;
    bit exp_valid;
    exp_valid = clken && m_full;
    if (clken) begin
      s = 0;
      for (int k = 0; k < NT; k++) if (tone_en[k]) s += lut_ref[m_acc[k] >> 22];
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      exp_q.push_back(s);
      for (int k = 0; k < NT; k++) m_acc[k] = m_acc[k] + m_inc[k];
      m_full = 1'b1;
    end
    if (m_pending) begin
      if (clken) begin
        for (int k = 0; k < NT; k++) m_inc[k] = m_shadow[k];
        m_pending = 1'b0;
      end
    end else if (commit) begin
      m_pending = 1'b1;
    end
    if (we && (int'(tone) < NT)) m_shadow[tone] = pinc;
    @(posedge clk);
    #1;
    check("valid", valid, exp_valid);
    check("ready", ready, !m_pending);
    if (valid) begin
      if (exp_q.size() == 0) check("spurious_valid", exp_q.size(), 1);
      else check("data", data, exp_q.pop_front());
      if (int'(data) > obs_max) obs_max = int'(data);
      if (int'(data) < obs_min) obs_min = int'(data);
    end
    we = 1'b0;
    commit = 1'b0;
    clear_sat = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write_inc(input logic [1:0] t, input logic [31:0] v);
    we = 1'b1;
    tone = t;
    pinc = v;
    cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int k = 0; k < NT; k++) begin
      m_acc[k] = '0;
      m_inc[k] = '0;
      m_shadow[k] = '0;
    end
    m_pending = 1'b0;
    m_full = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_sat", sat, 0);
    check("rst_ready", ready, 1);
    we = 1'b0;
    commit = 1'b0;
    clear_sat = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    real v;
    logic signed [15:0] held;
    for (int k = 0; k < 1024; k++) begin
      v = 16383.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
      lut_ref[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    end

    // Reset held with busy stimulus.
    clken = 1'b1; tone_en = '1; we = 1'b1; tone = 2'd0; pinc = 32'h4000_0000;
    commit = 1'b1; clear_sat = 1'b1; rst_n = 1'b1;
    do_reset(10);

    // Single tone, quarter-cycle increment.
    do_reset(2);
    clken = 1'b0; tone_en = 3'b001;
    write_inc(2'd0, 32'h4000_0000);
    commit = 1'b1;
    cycle();
    clken = 1'b1;
    clear_obs();
    run(40);
    check("single_max", obs_max, 16383);
    check("single_min", obs_min, -16383);
    check("single_sat", sat, 0);

    // Two harness tones summed.
    do_reset(2);
    clken = 1'b0; tone_en = 3'b011;
    write_inc(2'd0, 32'd85899346);
    write_inc(2'd1, 32'd515396076);
    commit = 1'b1;
    cycle();
    clken = 1'b1;
    clear_obs();
    run(300);
    check("harness_peak_ok", (obs_max <= 32766) && (obs_min >= -32766), 1);
    check("harness_sat", sat, 0);

    // All tones in phase drive the sum into both rails.
    do_reset(2);
    clken = 1'b0; tone_en = 3'b111;
    for (int k = 0; k < NT; k++) write_inc(2'(k), 32'h4000_0000);
    commit = 1'b1;
    cycle();
    clken = 1'b1;
    clear_obs();
    run(20);
    check("sat_max", obs_max, 32767);
    check("sat_min", obs_min, -32768);
    check("sat_set", sat, 1);
    tone_en = 3'b000;
    run(4);
    check("sat_sticky", sat, 1);
    clear_sat = 1'b1;
    cycle();
    check("sat_cleared", sat, 0);
    run(3);
    check("sat_stays_clear", sat, 0);

    // Commit handshake while the clock enable is low.
    clken = 1'b0;
    write_inc(2'd0, 32'h1000_0000);
    write_inc(2'd1, 32'h2000_0000);
    write_inc(2'd2, 32'd12345678);
    write_inc(2'd3, 32'h7777_7777);
    commit = 1'b1;
    cycle();
    check("hs_ready_low", ready, 0);
    held = data;
    commit = 1'b1;
    cycle();
    run(3);
    check("hs_frozen_data", data, held);
    check("hs_ready_still_low", ready, 0);
    tone_en = 3'b111;
    clken = 1'b1;
    we = 1'b1; tone = 2'd0; pinc = 32'hDEAD_BEEF;
    cycle();
    check("hs_ready_back", ready, 1);
    run(60);

    // Reset while a commit is pending discards it and all increments.
    clken = 1'b0;
    write_inc(2'd0, 32'h4000_0000);
    commit = 1'b1;
    cycle();
    check("mid_ready_low", ready, 0);
    do_reset(3);
    clken = 1'b1; tone_en = 3'b111;
    clear_obs();
    run(10);
    commit = 1'b1;
    cycle();
    run(10);
    check("mid_zero_max", obs_max, 0);
    check("mid_zero_min", obs_min, 0);
    check("mid_data", data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
